// File: rtl/spp_host_sequencer_if.sv
// Bundle of the stream-in, matrix-write, engine-control and result ports of the
// SPP host sequencer; master is the sequencer, slave is its environment.
interface spp_host_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROWS   = 16,
    parameter int unsigned COLS   = 16,
    parameter int unsigned RES_W  = 32
);
    localparam int unsigned AW = $clog2(ROWS * COLS);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              spp_rst;
    logic              spp_go;
    logic              spp_done;
    logic [RES_W-1:0]  spp_result;
    logic              res_valid;
    logic              res_ready;
    logic [RES_W-1:0]  res_data;
    logic              res_err;
    logic              busy;

    modport master (
        input  in_valid, in_data, spp_done, spp_result, res_ready,
        output in_ready, mem_we, mem_waddr, mem_wdata, spp_rst, spp_go,
               res_valid, res_data, res_err, busy
    );

    modport slave (
        output in_valid, in_data, spp_done, spp_result, res_ready,
        input  in_ready, mem_we, mem_waddr, mem_wdata, spp_rst, spp_go,
               res_valid, res_data, res_err, busy
    );
endinterface

// File: rtl/spp_host_sequencer.sv
// SPP host sequencer: streams a ROWSxCOLS matrix into SPP memory row-major,
// restarts and starts the engine, then returns its result or a watchdog error.
module spp_host_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned RES_W   = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                  clk,
    input logic                  reset,
    spp_host_sequencer_if.master bus
);
    localparam int unsigned NUM_EL = ROWS * COLS;
    localparam int unsigned AW     = $clog2(NUM_EL);
    localparam int unsigned WCW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {LOAD, CLR, GO, WAIT, HOLD} state_t;

    state_t           state;
    logic [AW-1:0]    wr_cnt;
    logic [WCW-1:0]   watch_cnt;
    logic             in_ready_q;
    logic             spp_rst_q;
    logic             spp_go_q;
    logic             res_valid_q;
    logic             res_err_q;
    logic             busy_q;
    logic [RES_W-1:0] res_data_q;
    logic             accept_c;

    assign accept_c = bus.in_valid & in_ready_q;

    // Zero-latency write path: the accepted beat is written in its own cycle
    assign bus.mem_we    = accept_c;
    assign bus.mem_waddr = wr_cnt;
    assign bus.mem_wdata = bus.in_data;

    assign bus.in_ready  = in_ready_q;
    assign bus.spp_rst   = spp_rst_q;
    assign bus.spp_go    = spp_go_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= LOAD;
            wr_cnt      <= '0;
            watch_cnt   <= '0;
            in_ready_q  <= 1'b1;
            spp_rst_q   <= 1'b0;
            spp_go_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            spp_rst_q <= 1'b0;
            spp_go_q  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept_c) begin
                        busy_q <= 1'b1;
                        if (wr_cnt == AW'(NUM_EL - 1)) begin
                            wr_cnt     <= '0;
                            in_ready_q <= 1'b0;
                            spp_rst_q  <= 1'b1;
                            state      <= CLR;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                        end
                    end
                end
                // Engine parks in its hold state after done, so restart it first
                CLR: begin
                    spp_go_q <= 1'b1;
                    state    <= GO;
                end
                GO: begin
                    watch_cnt <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (watch_cnt != WCW'(TIMEOUT)) begin
                        watch_cnt <= watch_cnt + WCW'(1);
                    end
                    if (bus.spp_done) begin
                        res_data_q  <= bus.spp_result;
                        res_err_q   <= 1'b0;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else if (watch_cnt == WCW'(TIMEOUT - 1)) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spp_host_sequencer.sv
// Randomized bench for spp_host_sequencer with a behavioural SPP engine and a
// transaction-level expectation of writes, pulses and result timing.
module tb_spp_host_sequencer;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ROWS    = 16;
    localparam int unsigned COLS    = 16;
    localparam int unsigned RES_W   = 32;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned N       = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;

    spp_host_sequencer_if #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .RES_W(RES_W)) bus ();

    spp_host_sequencer #(
        .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .RES_W(RES_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned cyc;
        int unsigned addr;
        int unsigned data;
    } wr_t;

    int unsigned       n_tests;
    int unsigned       n_fail;
    int unsigned       run_id;
    int unsigned       cyc;
    logic [DATA_W-1:0] mat  [N];
    logic [DATA_W-1:0] emem [N];
    wr_t               wr_q [$];
    int unsigned       rst_q[$];
    int unsigned       go_q [$];

    int unsigned       snap_cyc;
    int unsigned       last_acc_cyc;
    bit                acc;
    bit                snap_valid;
    bit                snap_err;
    bit                snap_in_ready;
    bit                snap_busy;
    logic [RES_W-1:0]  snap_data;

    int unsigned       eng_lat;
    int unsigned       done_at;
    bit                eng_armed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL run%0d %s: got 0x%0h expected 0x%0h", run_id, tag, got, exp);
        end
    endtask

    // Product of the even-valued elements, modulo 2^32
    function automatic logic [31:0] even_prod(input logic [DATA_W-1:0] m [N]);
        logic [31:0] p = 32'd1;
        for (int k = 0; k < int'(N); k++) begin
            if (m[k][0] == 1'b0) p = p * 32'(m[k]);
        end
        return p;
    endfunction

    // One clock: observe at negedge, then advance the engine model after posedge
    task automatic step();
        bit  saw_rst;
        bit  saw_go;
        wr_t w;
        @(negedge clk);
        snap_cyc      = cyc;
        acc           = bus.in_valid && bus.in_ready;
        snap_valid    = bus.res_valid;
        snap_err      = bus.res_err;
        snap_data     = bus.res_data;
        snap_in_ready = bus.in_ready;
        snap_busy     = bus.busy;
        saw_rst       = bus.spp_rst;
        saw_go        = bus.spp_go;
        if (bus.mem_we) begin
            w.cyc  = cyc;
            w.addr = 32'(bus.mem_waddr);
            w.data = 32'(bus.mem_wdata);
            wr_q.push_back(w);
            emem[bus.mem_waddr] = bus.mem_wdata;
        end
        if (saw_rst) rst_q.push_back(cyc);
        if (saw_go)  go_q.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        if (saw_rst) eng_armed = 1'b0;
        if (saw_go) begin
            eng_armed = (eng_lat != 0);
            done_at   = snap_cyc + eng_lat;
        end
        if (eng_armed && cyc >= done_at) begin
            if (!bus.spp_done) bus.spp_result = even_prod(emem);
            bus.spp_done = 1'b1;
        end else begin
            bus.spp_done   = 1'b0;
            bus.spp_result = $urandom();
        end
    endtask

    task automatic check_reset_vals();
        check("rv_in_ready",  32'(bus.in_ready),  32'd1);
        check("rv_mem_we",    32'(bus.mem_we),    32'd0);
        check("rv_mem_waddr", 32'(bus.mem_waddr), 32'd0);
        check("rv_spp_rst",   32'(bus.spp_rst),   32'd0);
        check("rv_spp_go",    32'(bus.spp_go),    32'd0);
        check("rv_res_valid", 32'(bus.res_valid), 32'd0);
        check("rv_res_data",  bus.res_data,       32'd0);
        check("rv_res_err",   32'(bus.res_err),   32'd0);
        check("rv_busy",      32'(bus.busy),      32'd0);
    endtask

    task automatic gen_matrix();
        for (int k = 0; k < int'(N); k++) begin
            if ($urandom_range(99) < 4) mat[k] = DATA_W'($urandom_range(127, 1)) << 1;
            else                        mat[k] = DATA_W'($urandom_range(255)) | DATA_W'(1);
        end
    endtask

    task automatic load_matrix(input int unsigned pct);
        int unsigned idx   = 0;
        int unsigned guard = 0;
        while (idx < N && guard < N * 8) begin
            bus.in_valid = ($urandom_range(99) < pct);
            bus.in_data  = mat[idx];
            step();
            if (bus.in_valid) check("ld_in_ready", 32'(snap_in_ready), 32'd1);
            if (acc) begin
                last_acc_cyc = snap_cyc;
                idx++;
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check("ld_beats", idx, N);
    endtask

    task automatic run(input int unsigned lat, input int unsigned pct, input int unsigned hold_n);
        logic [31:0] exp_d;
        bit          exp_e;
        int unsigned exp_gap;
        int unsigned t;
        int unsigned g;
        int unsigned n;
        wr_q.delete();
        rst_q.delete();
        go_q.delete();
        eng_lat = lat;
        load_matrix(pct);
        t = last_acc_cyc;
        n = 0;
        while (!snap_valid && n < TIMEOUT + 64) begin
            step();
            n++;
        end
        check("res_seen", 32'(snap_valid), 32'd1);
        if (lat != 0 && lat <= TIMEOUT) begin
            exp_d = even_prod(mat); exp_e = 1'b0; exp_gap = lat + 1;
        end else begin
            exp_d = 32'd0; exp_e = 1'b1; exp_gap = TIMEOUT + 1;
        end
        check("wr_count", 32'(wr_q.size()), N);
        for (int k = 0; k < wr_q.size() && k < int'(N); k++) begin
            check("wr_addr", wr_q[k].addr, 32'(k));
            check("wr_data", wr_q[k].data, 32'(mat[k]));
        end
        check("wr_last_cyc", (wr_q.size() > 0) ? wr_q[wr_q.size()-1].cyc : 32'd0, t);
        check("rst_count", 32'(rst_q.size()), 32'd1);
        check("rst_cyc", (rst_q.size() > 0) ? rst_q[0] : 32'd0, t + 1);
        check("go_count", 32'(go_q.size()), 32'd1);
        check("go_cyc", (go_q.size() > 0) ? go_q[0] : 32'd0, t + 2);
        g = (go_q.size() > 0) ? go_q[0] : 0;
        check("res_gap", snap_cyc - g, exp_gap);
        check("res_data", snap_data, exp_d);
        check("res_err", 32'(snap_err), 32'(exp_e));
        check("res_busy", 32'(snap_busy), 32'd1);
        // Consumer stalls while stray beats are offered
        for (int i = 0; i < int'(hold_n); i++) begin
            bus.res_ready = 1'b0;
            bus.in_valid  = 1'($urandom_range(1));
            bus.in_data   = DATA_W'($urandom());
            step();
            check("hold_valid", 32'(snap_valid), 32'd1);
            check("hold_data", snap_data, exp_d);
            check("hold_err", 32'(snap_err), 32'(exp_e));
            check("hold_in_ready", 32'(snap_in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        check("hold_no_wr", 32'(wr_q.size()), N);
        bus.res_ready = 1'b1;
        step();
        check("hs_valid", 32'(snap_valid), 32'd1);
        bus.res_ready = 1'b0;
        step();
        check("post_valid", 32'(snap_valid), 32'd0);
        check("post_in_ready", 32'(snap_in_ready), 32'd1);
        check("post_busy", 32'(snap_busy), 32'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; run_id = 0; cyc = 0;
        eng_armed = 1'b0; eng_lat = 0; done_at = 0; last_acc_cyc = 0;
        snap_valid = 1'b0;
        for (int k = 0; k < int'(N); k++) emem[k] = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.spp_done = 1'b0;
        bus.spp_result = '0; bus.res_ready = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals();
        repeat (2) step();
        check_reset_vals();
        reset = 1'b0;

        run_id = 1;
        for (int k = 0; k < int'(N); k++) mat[k] = 8'd1;
        mat[0] = 8'd2;
        mat[N-1] = 8'd4;
        run(7, 100, 20);

        run_id = 2; gen_matrix(); run($urandom_range(40, 1), 50, $urandom_range(5));
        run_id = 3; gen_matrix(); run(0, 70, 2);
        run_id = 4; gen_matrix(); run(TIMEOUT, 80, 1);
        run_id = 5; gen_matrix(); run(TIMEOUT + 1, 80, 1);

        // Reset in the middle of WAIT, then a clean second load
        run_id = 6;
        gen_matrix();
        wr_q.delete(); rst_q.delete(); go_q.delete();
        eng_lat = 600;
        load_matrix(60);
        repeat (30) step();
        check("mid_busy", 32'(snap_busy), 32'd1);
        check("mid_valid", 32'(snap_valid), 32'd0);
        reset = 1'b1;
        #1 check_reset_vals();
        repeat (3) begin
            step();
            check_reset_vals();
        end
        reset = 1'b0;
        run_id = 7; gen_matrix(); run(12, 60, 3);

        for (int r = 0; r < 3; r++) begin
            run_id = 8 + 32'(r);
            gen_matrix();
            run($urandom_range(60, 1), $urandom_range(90, 40), $urandom_range(4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/spp_host_sequencer.md
# spp_host_sequencer

Initiator-side companion to the SPP control unit/datapath. Accepts a streamed ROWS×COLS matrix of elements and writes it into the SPP matrix memory in row-major order. It then restarts the SPP engine, pulses its start input and waits for its done flag. The captured product-of-even-elements result is presented on a valid/ready output port, with a watchdog error if the engine never finishes.

## Interface
- DATA_W, 8, element width
- ROWS, 16, matrix rows
- COLS, 16, matrix columns
- RES_W, 32, SPP result width
- TIMEOUT, 1023, max cycles to wait for spp_done (≥ 1)
- AW, $clog2(ROWS*COLS), write-address width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  element beat valid
- in_ready  out  1  block accepts element beat
- in_data  in  DATA_W  element value
- mem_we  out  1  matrix memory write enable
- mem_waddr  out  AW  write address, row-major (i*COLS + j)
- mem_wdata  out  DATA_W  write data
- spp_rst  out  1  one-cycle restart pulse to SPP engine
- spp_go  out  1  one-cycle start pulse (drives engine go_i)
- spp_done  in  1  engine done flag (level, held until engine reset)
- spp_result  in  RES_W  engine result, valid while spp_done=1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  RES_W  captured result (0 on error)
- res_err  out  1  qualifies res_data: 1 = watchdog timeout
- busy  out  1  high in every state except LOAD with wr_cnt=0

## Operation
- States: LOAD, CLR, GO, WAIT, HOLD. Reset state LOAD.
- LOAD: in_ready=1. Beat accepted when in_valid&in_ready. On accept: mem_we=1, mem_waddr=wr_cnt, mem_wdata=in_data (combinational from handshake), wr_cnt increments. On the accept at wr_cnt=ROWS*COLS−1: wr_cnt wraps to 0, next state CLR.
- CLR: spp_rst=1 for one cycle → GO. Required because the engine parks in its hold state after done.
- GO: spp_go=1 for one cycle; watchdog counter cleared → WAIT.
- WAIT: watch_cnt increments each cycle.
  - spp_done=1: res_data←spp_result, res_err←0 → HOLD.
  - else if watch_cnt=TIMEOUT−1: res_data←0, res_err←1 → HOLD.
  - spp_done has priority if both occur in the same cycle.
- HOLD: res_valid=1; res_data and res_err stable. On res_valid&res_ready → LOAD next cycle.
- in_ready=0 in every state except LOAD; in_data is ignored there.
- Arithmetic:
  - wr_cnt is AW bits, wraps explicitly at ROWS*COLS (not only at 2^AW).
  - watch_cnt is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values:
  - in_ready=1, mem_we=0, mem_waddr=0, spp_rst=0, spp_go=0
  - res_valid=0, res_data=0, res_err=0, busy=0
  - wr_cnt=0, watch_cnt=0
- Write path has zero latency: write issued in the accept cycle.
- Last beat at cycle t: spp_rst at t+1, spp_go at t+2, WAIT from t+3.
- spp_done sampled high at cycle d: res_valid=1 from d+1.
- Timeout: res_valid rises exactly TIMEOUT+1 cycles after the spp_go cycle.
- Consumer handshake at cycle h: res_valid=0 and in_ready=1 at h+1. A new beat can be accepted at h+1.
- Reset mid-operation (any state) takes effect immediately:
  - all outputs go to reset values; partial load discarded; wr_cnt=0.
  - the engine is not pulsed by this block; the next run's CLR restarts it.
- spp_done high outside WAIT is ignored.

## Test plan
- Full load, all elements 1 except [0][0]=2 and [15][15]=4, with an SPP behavioural model → writes to addresses 0..255 in order; spp_rst then spp_go pulses; res_data=8, res_err=0.
- in_valid toggled pseudo-randomly during load → exactly 256 writes, no skipped or duplicated addresses, no spp_go before the 256th accept.
- Model never raises spp_done → res_valid exactly 1024 cycles after spp_go; res_err=1, res_data=0.
- res_ready held low 20 cycles in HOLD → res_valid, res_data, res_err stable; in_ready=0; extra in_valid beats are not written.
- spp_done rises in the same cycle watch_cnt reaches 1022 → res_err=0, res_data=spp_result.
- reset asserted mid-WAIT, then a second full load → outputs at reset values during reset; second run writes from address 0; correct result is produced.
